// File: rtl/soma_sweep_if.sv
// soma_sweep_if: bundle between the sweep controller and its neighbours.
//   soma_vld / soma_addr / soma_clear : neuron update strobe towards the soma
//   soma_fire                         : soma fire flag, valid the cycle after soma_vld
//   spk_vld / spk_addr / spk_rdy      : fired-neuron stream towards the spike packer
// master = sweep controller side, slave = soma + downstream side.
interface soma_sweep_if #(
    parameter int NNW = 12
);
    logic           soma_vld;
    logic [NNW-1:0] soma_addr;
    logic           soma_clear;
    logic           soma_fire;
    logic           spk_vld;
    logic [NNW-1:0] spk_addr;
    logic           spk_rdy;

    modport master (
        output soma_vld, soma_addr, soma_clear,
        input  soma_fire,
        output spk_vld, spk_addr,
        input  spk_rdy
    );

    modport slave (
        input  soma_vld, soma_addr, soma_clear,
        output soma_fire,
        input  spk_vld, spk_addr,
        output spk_rdy
    );
endinterface

// File: rtl/soma_sweep_ctrl.sv
// soma_sweep_ctrl: per-timestep sweep over all neurons of the soma.
// On i_tick_start it strobes neuron addresses 0..N-1 to the soma, samples the
// fire flag one cycle after each strobe and queues fired indices in a small
// show-ahead FIFO that is drained on a valid/ready handshake.
//
// Ports:
//   clk_soma, rst      : clock, synchronous active-high reset
//   i_tick_start       : one-cycle pulse, start a sweep
//   i_tick_clear       : sampled with i_tick_start, 1 = clear sweep (no fire sampling)
//   i_neuron_num       : neurons to sweep, sampled with i_tick_start, clamped to 2**NNW
//   o_busy             : sweep in progress
//   o_done             : one-cycle pulse at sweep completion
//   o_overrun          : one-cycle pulse, i_tick_start arrived while busy
//   o_spk_count        : fires pushed during the last sweep (SOMA_SWEEP_CNT_EN only)
//   bus (master)       : soma strobe + fire flag, spike output stream
//
// Build option: define SOMA_SWEEP_CNT_EN to add the o_spk_count port and counter.
//
// state  | meaning
// IDLE   | waiting for i_tick_start
// SWEEP  | issuing soma strobes, stalls while the FIFO could overflow
// DRAIN  | all strobes issued, waiting for last fire sample and empty FIFO
// DONE   | o_done pulse, back to IDLE
module soma_sweep_ctrl #(
    parameter int NNW     = 12,
    parameter int FIFO_AW = 3
) (
    input  logic           clk_soma,
    input  logic           rst,
    input  logic           i_tick_start,
    input  logic           i_tick_clear,
    input  logic [NNW:0]   i_neuron_num,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_overrun,
`ifdef SOMA_SWEEP_CNT_EN
    output logic [NNW:0]   o_spk_count,
`endif
    soma_sweep_if.master   bus
);
    localparam int           DEPTH   = 1 << FIFO_AW;
    localparam logic [NNW:0] NUM_MAX = {1'b1, {NNW{1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DRAIN, ST_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NNW:0]         r_num;
    logic [NNW:0]         r_addr;
    logic                 r_clear;
    logic                 r_soma_vld;
    logic [NNW-1:0]       r_soma_addr;
    logic                 r_soma_clear;
    logic                 r_infl_vld;
    logic [NNW-1:0]       r_infl_addr;
    logic                 r_infl_clear;
    logic                 r_overrun;
    logic [NNW-1:0]       r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;

    logic [NNW:0]         w_num_clamped;
    logic [FIFO_AW+1:0]   w_pending;
    logic                 w_room;
    logic                 w_issue;
    logic [NNW-1:0]       w_issue_addr;
    logic                 w_issue_clear;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_empty;
    logic                 w_start_acc;

    assign w_num_clamped = (i_neuron_num > NUM_MAX) ? NUM_MAX : i_neuron_num;
    assign w_start_acc   = (r_state == ST_IDLE) && i_tick_start;

    // Every strobe already on the wire or awaiting its fire sample may still
    // push, so it reserves a FIFO slot before the next strobe is allowed.
    assign w_pending = (FIFO_AW+2)'(r_count) + (FIFO_AW+2)'(r_soma_vld)
                     + (FIFO_AW+2)'(r_infl_vld);
    assign w_room    = r_clear || (w_pending < (FIFO_AW+2)'(DEPTH));

    assign w_fifo_empty = (r_count == '0);
    assign w_push       = r_infl_vld && !r_infl_clear && bus.soma_fire;
    assign w_pop        = !w_fifo_empty && bus.spk_rdy;

    always_comb begin
        w_state_nxt   = r_state;
        w_issue       = 1'b0;
        w_issue_addr  = r_addr[NNW-1:0];
        w_issue_clear = r_clear;
        case (r_state)
            ST_IDLE: begin
                if (i_tick_start) begin
                    // Address 0 is issued straight from IDLE so the first
                    // strobe appears the cycle after the tick.
                    w_issue_addr  = '0;
                    w_issue_clear = i_tick_clear;
                    if (w_num_clamped == '0) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = (w_num_clamped == (NNW+1)'(1)) ? ST_DRAIN : ST_SWEEP;
                    end
                end
            end
            ST_SWEEP: begin
                if (w_room) begin
                    w_issue = 1'b1;
                    if (r_addr == r_num - (NNW+1)'(1)) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // A non-firing final sample resolves the sweep in this cycle.
                if (!r_soma_vld && !w_push && w_fifo_empty) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_soma) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_num        <= '0;
            r_addr       <= '0;
            r_clear      <= 1'b0;
            r_soma_vld   <= 1'b0;
            r_soma_addr  <= '0;
            r_soma_clear <= 1'b0;
            r_infl_vld   <= 1'b0;
            r_infl_addr  <= '0;
            r_infl_clear <= 1'b0;
            r_overrun    <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_num   <= w_num_clamped;
                r_clear <= i_tick_clear;
                r_addr  <= w_issue ? (NNW+1)'(1) : '0;
            end else if (w_issue) begin
                r_addr <= r_addr + (NNW+1)'(1);
            end
            r_soma_vld   <= w_issue;
            r_soma_addr  <= w_issue ? w_issue_addr : '0;
            r_soma_clear <= w_issue && w_issue_clear;
            r_infl_vld   <= r_soma_vld;
            r_infl_addr  <= r_soma_addr;
            r_infl_clear <= r_soma_clear;
            r_overrun    <= i_tick_start && (r_state != ST_IDLE);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_soma) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_infl_addr;
        end
    end

`ifdef SOMA_SWEEP_CNT_EN
    logic [NNW:0] r_run_cnt;
    logic [NNW:0] r_spk_count;

    always_ff @(posedge clk_soma) begin
        if (rst) begin
            r_run_cnt   <= '0;
            r_spk_count <= '0;
        end else begin
            if (w_start_acc) begin
                r_run_cnt <= '0;
            end else if (w_push) begin
                r_run_cnt <= r_run_cnt + (NNW+1)'(1);
            end
            // No push can coincide with the DRAIN exit, so r_run_cnt is final.
            if ((r_state == ST_DRAIN) && (w_state_nxt == ST_DONE)) begin
                r_spk_count <= r_run_cnt;
            end
        end
    end

    assign o_spk_count = r_spk_count;
`endif

    assign bus.soma_vld   = r_soma_vld;
    assign bus.soma_addr  = r_soma_addr;
    assign bus.soma_clear = r_soma_clear;
    assign bus.spk_vld    = !w_fifo_empty;
    assign bus.spk_addr   = w_fifo_empty ? '0 : r_mem[r_rd_ptr];
    assign o_busy         = (r_state != ST_IDLE);
    assign o_done         = (r_state == ST_DONE);
    assign o_overrun      = r_overrun;
endmodule
